// File: rtl/debug_tx_pkg.sv
// Shared types and constants for the debug-bus UART transmitter.
package debug_tx_pkg;

  localparam logic [5:0] SYNC_TAG     = 6'b101010;
  localparam int         RECORD_BYTES = 3;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
  } record_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Byte 0 carries the sync tag, the overflow snapshot and the rw flag.
  function automatic logic [7:0] record_byte(record_t rec, logic ovf, logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0:    b = {SYNC_TAG, ovf, rec.rw};
      2'd1:    b = rec.addr[15:8];
      default: b = rec.addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_tx_fifo.sv
// Show-ahead synchronous FIFO of captured bus records; head is valid whenever not empty.
module debug_tx_fifo
  import debug_tx_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  logic    pop,
  input  record_t wdata,
  output record_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  record_t            mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_ok;
  logic               pop_ok;

  // Full is judged on the pre-pop count, so a push at full is refused even alongside a pop.
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debug_bus_uart_tx.sv
// Captures debug bus cycles into a FIFO and streams each as a 3-byte 8N1 record.
// Optional address window filter enabled by defining DEBUG_TX_FILTER_EN.
//
// state | meaning
// IDLE  | line high, pops next record when FIFO non-empty
// START | start bit (0) for the current byte
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1), then next byte or back to IDLE
module debug_bus_uart_tx
  import debug_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] ba,
  input  logic        rw,
  input  logic [15:0] filt_lo,
  input  logic [15:0] filt_hi,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int            CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    LAST_BYTE    = 2'(RECORD_BYTES - 1);

  logic          qual;
  logic          sample_hit;
  logic          push;
  logic          drop;
  logic          pop;
  logic          full;
  logic          empty;
  record_t       sample_rec;
  record_t       head;
  record_t       rec;
  tx_state_e     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    shift;

`ifdef DEBUG_TX_FILTER_EN
  assign qual = (ba >= filt_lo) && (ba <= filt_hi);
`else
  logic unused_filt;
  assign unused_filt = ^{filt_lo, filt_hi};
  assign qual        = 1'b1;
`endif

  assign sample_hit = enable && sample_valid && qual;
  assign push       = sample_hit && !full;
  assign drop       = sample_hit && full;
  assign pop        = (state == IDLE) && !empty;
  assign sample_rec = '{addr: ba, rw: rw};

  debug_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (sample_rec),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );

  // A drop in the same cycle as a pop keeps the flag set for the next record.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (pop)  overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      rec      <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          busy     <= 1'b0;
          byte_idx <= '0;
          if (pop) begin
            rec     <= head;
            shift   <= record_byte(head, overflow, 2'd0);
            txd     <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= BIT_CNT_LOAD;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            txd     <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
            bit_cnt <= BIT_CNT_LOAD;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_CNT_LOAD;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            if (byte_idx == LAST_BYTE) begin
              busy     <= 1'b0;
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              shift    <= record_byte(rec, 1'b0, byte_idx + 2'd1);
              txd      <= 1'b0;
              bit_cnt  <= BIT_CNT_LOAD;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bus_uart_tx.sv
// Directed self-checking bench for debug_bus_uart_tx with CLKS_PER_BIT=4, FIFO_AW=4.
module tb_debug_bus_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] ba = '0;
  logic        rw = 1'b0;
  logic [15:0] filt_lo = '0;
  logic [15:0] filt_hi = '0;
  logic        txd;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic [7:0] exq[$];

  debug_bus_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .ba           (ba),
    .rw           (rw),
    .filt_lo      (filt_lo),
    .filt_hi      (filt_hi),
    .txd          (txd),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [15:0] a, input logic r);
    @(negedge clk);
    sample_valid = 1'b1;
    ba = a;
    rw = r;
  endtask

  task automatic release_bus();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic burst(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) drive(base + 16'(i), i[0]);
    release_bus();
  endtask

  task automatic expect_rec(input logic ovf, input logic r, input logic [15:0] a);
    exq.push_back({6'b101010, ovf, r});
    exq.push_back(a[15:8]);
    exq.push_back(a[7:0]);
  endtask

  // UART receiver: waits for a start bit, samples each bit near its centre.
  task automatic recv_bytes(input int n);
    logic [7:0] b;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (txd !== 1'b0 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (txd !== 1'b0) begin
        errors++;
        $display("FAIL rx_start: byte %0d txd=%b, required start bit 0 within 2000 clocks", k, txd);
        return;
      end
      repeat (CPB / 2) @(negedge clk);
      b = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        errors++;
        $display("FAIL rx_stop: byte %0d stop bit txd=%b, required 1", k, txd);
      end
      rxq.push_back(b);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd=%b busy=%b overflow=%b, required 1 0 0", txd, busy, overflow);
    end
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_single_write();
    int bc;
    rxq.delete(); exq.delete();
    expect_rec(1'b0, 1'b0, 16'h9C40);
    drive(16'h9C40, 1'b0);
    release_bus();
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: txd=%b one clock after strobe, required 1", txd);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_start: txd=%b busy=%b two clocks after strobe, required 0 1", txd, busy);
    end
    bc = 0;
    fork
      recv_bytes(3);
      begin
        while (busy === 1'b1 && bc < 1000) begin
          bc++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (bc != 30 * CPB) begin
      errors++;
      $display("FAIL busy_span: busy high %0d clocks, required %0d", bc, 30 * CPB);
    end
    checks++;
    if (rxq.size() != exq.size()) begin
      errors++;
      $display("FAIL single_count: got %0d bytes, required %0d", rxq.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exq[i]) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %h, required %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int bad;
    drive(16'h5555, 1'b0);
    release_bus();
    repeat (2) @(negedge clk);
    burst(16'h6000, 17);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ovf: overflow=%b, required 1", overflow);
    end
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: txd=%b busy=%b overflow=%b, required 1 0 0", txd, busy, overflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: %0d active clocks, required 0", bad);
    end
  endtask

  task automatic test_read();
    rxq.delete(); exq.delete();
    expect_rec(1'b0, 1'b1, 16'h0001);
    drive(16'h0001, 1'b1);
    release_bus();
    recv_bytes(3);
    checks++;
    if (rxq.size() != exq.size()) begin
      errors++;
      $display("FAIL read_count: got %0d bytes, required %0d", rxq.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exq[i]) begin
        errors++;
        $display("FAIL read_byte[%0d]: got %h, required %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
      end
    end
  endtask

  // One record in flight, then 20 strobes: 16 fill the FIFO, 4 are dropped.
  task automatic test_overflow();
    int bad;
    rxq.delete(); exq.delete();
    expect_rec(1'b0, 1'b0, 16'h1234);
    for (int i = 0; i < 16; i++) expect_rec(i == 0, i[0], 16'hA000 + 16'(i));
    drive(16'h1234, 1'b0);
    release_bus();
    fork
      recv_bytes(51);
      begin
        repeat (2) @(negedge clk);
        burst(16'hA000, 20);
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set: overflow=%b after drops, required 1", overflow);
        end
      end
    join
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b after report, required 0", overflow);
    end
    checks++;
    if (rxq.size() != exq.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d bytes, required %0d", rxq.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exq[i]) begin
        errors++;
        $display("FAIL ovf_byte[%0d]: got %h, required %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
      end
    end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_no_extra: %0d clocks of extra output, required 0", bad);
    end
  endtask

  task automatic test_enable_drain();
    int bad;
    rxq.delete(); exq.delete();
    expect_rec(1'b0, 1'b0, 16'hC000);
    expect_rec(1'b0, 1'b1, 16'hC001);
    expect_rec(1'b0, 1'b0, 16'hC002);
    fork
      recv_bytes(9);
      begin
        burst(16'hC000, 3);
        enable = 1'b0;
        burst(16'hD000, 3);
      end
    join
    checks++;
    if (rxq.size() != exq.size()) begin
      errors++;
      $display("FAIL drain_count: got %0d bytes, required %0d", rxq.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exq[i]) begin
        errors++;
        $display("FAIL drain_byte[%0d]: got %h, required %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
      end
    end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL disabled_capture: %0d active clocks overflow=%b, required 0 0", bad, overflow);
    end
    enable = 1'b1;
  endtask

  task automatic test_filter();
    int nbytes;
    int bad;
    rxq.delete(); exq.delete();
    filt_lo = 16'h8000;
    filt_hi = 16'h8FFF;
`ifdef DEBUG_TX_FILTER_EN
    expect_rec(1'b0, 1'b0, 16'h8000);
    expect_rec(1'b0, 1'b0, 16'h8FFF);
`else
    expect_rec(1'b0, 1'b0, 16'h7FFF);
    expect_rec(1'b0, 1'b0, 16'h8000);
    expect_rec(1'b0, 1'b0, 16'h8FFF);
    expect_rec(1'b0, 1'b0, 16'h9000);
`endif
    nbytes = exq.size();
    fork
      recv_bytes(nbytes);
      begin
        drive(16'h7FFF, 1'b0);
        drive(16'h8000, 1'b0);
        drive(16'h8FFF, 1'b0);
        drive(16'h9000, 1'b0);
        release_bus();
      end
    join
    checks++;
    if (rxq.size() != exq.size()) begin
      errors++;
      $display("FAIL filter_count: got %0d bytes, required %0d", rxq.size(), exq.size());
    end
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exq[i]) begin
        errors++;
        $display("FAIL filter_byte[%0d]: got %h, required %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
      end
    end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL filter_no_extra: %0d clocks of extra output, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_reset_mid_byte();
    test_read();
    test_overflow();
    test_enable_drain();
    test_filter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
